// File: rtl/fifo_pkg.sv
// Shared definitions for the register FIFO and its read-side unpacker: default
// widths, unpacker state encoding and beat slicing helpers.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 128;
   localparam int DEF_OUT_WIDTH  = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SEND
   } unpack_state_t;

   function automatic int num_beats(input int data_width, input int out_width);
      return data_width / out_width;
   endfunction

   // Bit offset of beat idx inside a wide word for either beat ordering.
   function automatic int slice_lsb(input int idx, input int beats, input int out_width,
                                    input bit msb_first);
      return msb_first ? (beats - 1 - idx) * out_width : idx * out_width;
   endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// Read-side consumer of the wide register FIFO: fetches one word at a time and
// replays it as narrow valid/ready beats, marking the last beat of each word.
module fifo_unpacker
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  srst,
   input  logic                  fifo_mty,
   input  logic [DATA_WIDTH-1:0] fifo_q,
   output logic                  fifo_rd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_last,
   output logic                  busy
);

   localparam int BEATS = num_beats(DATA_WIDTH, OUT_WIDTH);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   if ((DATA_WIDTH % OUT_WIDTH) != 0 || BEATS < 2) begin : g_param_check
      $error("fifo_unpacker: DATA_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
   end

   unpack_state_t           state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0]   word_r;
   logic                    load;
   logic                    send_ok;

   // A reset in progress suppresses every outward strobe, so a beat offered
   // alongside srst is never seen as transferred.
   assign send_ok = !arst && !srst;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state  <= IDLE;
         cnt    <= '0;
         word_r <= '0;
      end else if (srst) begin
         state  <= IDLE;
         cnt    <= '0;
         word_r <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (load) begin
            word_r <= fifo_q;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load      = 1'b0;
      fifo_rd   = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_mty) begin
               fifo_rd   = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            load      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = SEND;
         end
         SEND: begin
            out_valid = 1'b1;
            out_last  = (cnt == LAST_CNT);
            if (out_ready) begin
               if (cnt == LAST_CNT) begin
                  // Chain straight into the next word when one is waiting.
                  if (!fifo_mty) begin
                     fifo_rd   = 1'b1;
                     state_nxt = WAIT;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!send_ok) begin
         fifo_rd   = 1'b0;
         out_valid = 1'b0;
         out_last  = 1'b0;
      end
   end

   assign out_data = word_r[slice_lsb(int'(cnt), BEATS, OUT_WIDTH, MSB_FIRST) +: OUT_WIDTH];
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker with a small behavioural FIFO on its read port.
module tb_fifo_unpacker;

   logic         clk = 1'b0;
   logic         arst;
   logic         srst;
   logic         fifo_mty;
   logic [127:0] fifo_q;
   logic         fifo_rd;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic         out_last;
   logic         busy;

   logic         fifo_rd_m;
   logic         out_valid_m;
   logic [31:0]  out_data_m;
   logic         out_last_m;
   logic         busy_m;

   logic         wr_en;
   logic [127:0] wr_data;
   logic [127:0] fq[$];

   int total = 0;
   int bad   = 0;

   int          cyc = 0;
   int          fall_cyc = 0;
   int          rise_cyc = 0;
   bit          mty_d = 1'b1;
   bit          ov_d = 1'b0;
   int          rd_bad = 0;
   logic [31:0] bq_d[$];
   logic [31:0] bq_d1[$];
   logic        bq_l[$];
   int          bq_c[$];
   int          rd_c[$];

   always #5 clk = ~clk;

   fifo_unpacker #(.DATA_WIDTH(128), .OUT_WIDTH(32), .MSB_FIRST(1'b0)) dut (
      .clk(clk), .arst(arst), .srst(srst), .fifo_mty(fifo_mty), .fifo_q(fifo_q),
      .fifo_rd(fifo_rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   // Same inputs as dut, so it follows an identical schedule with reversed beat order.
   fifo_unpacker #(.DATA_WIDTH(128), .OUT_WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .arst(arst), .srst(srst), .fifo_mty(fifo_mty), .fifo_q(fifo_q),
      .fifo_rd(fifo_rd_m), .out_valid(out_valid_m), .out_ready(out_ready),
      .out_data(out_data_m), .out_last(out_last_m), .busy(busy_m)
   );

   // Behavioural FIFO: registered q on rd, registered empty flag.
   always @(posedge clk or posedge arst) begin
      if (arst) begin
         fq.delete();
         fifo_mty <= 1'b1;
         fifo_q   <= '0;
      end else begin
         if (fifo_rd && fq.size() != 0) fifo_q <= fq.pop_front();
         if (wr_en) fq.push_back(wr_data);
         fifo_mty <= (fq.size() == 0);
      end
   end

   always @(posedge clk) begin
      cyc++;
      if (fifo_mty === 1'b0 && mty_d) fall_cyc = cyc;
      if (out_valid === 1'b1 && !ov_d) rise_cyc = cyc;
      mty_d = (fifo_mty !== 1'b0);
      ov_d  = (out_valid === 1'b1);
      if (out_valid && out_ready) begin
         bq_d.push_back(out_data);
         bq_d1.push_back(out_data_m);
         bq_l.push_back(out_last);
         bq_c.push_back(cyc);
      end
      if (fifo_rd) rd_c.push_back(cyc);
      if (fifo_rd && fifo_mty) rd_bad++;
   end

   function automatic logic [127:0] mk(input logic [31:0] b);
      return {b + 32'd3, b + 32'd2, b + 32'd1, b};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      bq_d.delete();
      bq_d1.delete();
      bq_l.delete();
      bq_c.delete();
      rd_c.delete();
      rd_bad = 0;
   endtask

   task automatic push(input logic [127:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_beats(input string tag, input int n, input int budget);
      int i = 0;
      while (bq_d.size() < n && i < budget) begin
         @(negedge clk);
         i++;
      end
      #1;
      check(tag, (bq_d.size() >= n), 1'b1);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         #1;
         if (out_valid === 1'b1) found = 1'b1;
      end
      check(tag, found, 1'b1);
   endtask

   localparam logic [127:0] W2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

   initial begin
      logic [31:0] base;
      bit          found;
      arst = 1'b1; srst = 1'b0; out_ready = 1'b1; wr_en = 1'b0; wr_data = '0;
      repeat (2) @(negedge clk);
      #1;
      // reset state
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rd", fifo_rd, 1'b0);
      check("rst_last", out_last, 1'b0);
      check("rst_data", out_data, 32'h0);
      @(negedge clk);
      arst = 1'b0;
      repeat (2) @(negedge clk);

      // single word, LSB-first and MSB-first instances together
      clear_logs();
      push(W2);
      wait_beats("t2_timeout", 4, 30);
      check("t2_beat0", bq_d[0], 32'h03020100);
      check("t2_beat1", bq_d[1], 32'h07060504);
      check("t2_beat2", bq_d[2], 32'h0B0A0908);
      check("t2_beat3", bq_d[3], 32'h0F0E0D0C);
      check("t2_last0", bq_l[0], 1'b0);
      check("t2_last2", bq_l[2], 1'b0);
      check("t2_last3", bq_l[3], 1'b1);
      check("t2_rd_count", rd_c.size(), 1);
      check("t2_latency", rise_cyc - fall_cyc, 2);
      check("t6_first", bq_d1[0], 32'h0F0E0D0C);
      check("t6_second", bq_d1[1], 32'h0B0A0908);
      check("t6_last", bq_d1[3], 32'h03020100);
      repeat (2) @(negedge clk);
      #1;
      check("t2_idle_busy", busy, 1'b0);

      // four queued words back to back
      @(negedge clk);
      clear_logs();
      for (int k = 0; k < 4; k++) push(mk(32'h1000_0000 * (k + 1)));
      wait_beats("t3_timeout", 16, 60);
      for (int k = 0; k < 4; k++) begin
         base = 32'h1000_0000 * (k + 1);
         for (int b = 0; b < 4; b++) begin
            check($sformatf("t3_w%0d_b%0d", k, b), bq_d[k*4+b], base + b);
            check($sformatf("t3_w%0d_l%0d", k, b), bq_l[k*4+b], (b == 3));
         end
      end
      check("t3_rd_count", rd_c.size(), 4);
      for (int k = 0; k < 3; k++) check($sformatf("t3_rd_gap%0d", k), rd_c[k+1] - rd_c[k], 5);
      check("t3_span", bq_c[15] - rd_c[0], 20);
      check("t3_rd_while_mty", rd_bad, 0);
      repeat (3) @(negedge clk);

      // backpressure on beat 2 with a second word waiting
      clear_logs();
      push(mk(32'hA000_0000));
      push(mk(32'hB000_0000));
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         #1;
         if (out_valid === 1'b1 && out_data === 32'hA000_0002) found = 1'b1;
      end
      check("t4_reach_beat2", found, 1'b1);
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check($sformatf("t4_hold_data%0d", i), out_data, 32'hA000_0002);
         check($sformatf("t4_hold_last%0d", i), out_last, 1'b0);
         check($sformatf("t4_hold_valid%0d", i), out_valid, 1'b1);
         check($sformatf("t4_hold_rd%0d", i), fifo_rd, 1'b0);
         @(negedge clk);
         #1;
      end
      out_ready = 1'b1;
      wait_beats("t4_timeout", 8, 40);
      for (int b = 0; b < 4; b++) begin
         check($sformatf("t4_a%0d", b), bq_d[b], 32'hA000_0000 + b);
         check($sformatf("t4_b%0d", b), bq_d[4+b], 32'hB000_0000 + b);
      end
      check("t4_rd_count", rd_c.size(), 2);
      check("t4_rd_while_mty", rd_bad, 0);

      // empty boundary, then a fresh word from IDLE
      repeat (3) @(negedge clk);
      #1;
      check("t5_busy", busy, 1'b0);
      check("t5_valid", out_valid, 1'b0);
      check("t5_rd", fifo_rd, 1'b0);
      @(negedge clk);
      clear_logs();
      push(mk(32'hC000_0000));
      wait_beats("t5_timeout", 4, 30);
      check("t5_latency", rise_cyc - fall_cyc, 2);
      check("t5_beat0", bq_d[0], 32'hC000_0000);
      check("t5_beat3", bq_d[3], 32'hC000_0003);
      check("t5_last3", bq_l[3], 1'b1);

      // asynchronous reset in the middle of SEND
      repeat (3) @(negedge clk);
      clear_logs();
      push(mk(32'hD000_0000));
      wait_valid("t1_reach_send", 20);
      arst = 1'b1;
      #1;
      check("t1_valid", out_valid, 1'b0);
      check("t1_busy", busy, 1'b0);
      check("t1_rd", fifo_rd, 1'b0);
      check("t1_data", out_data, 32'h0);
      @(negedge clk);
      arst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("t1_idle_busy", busy, 1'b0);
      check("t1_no_beats", bq_d.size(), 0);

      // synchronous clear collides with an accepted-looking beat
      clear_logs();
      push(mk(32'hE000_0000));
      wait_valid("srst_reach_send", 20);
      srst = 1'b1;
      #1;
      check("srst_valid", out_valid, 1'b0);
      check("srst_rd", fifo_rd, 1'b0);
      @(negedge clk);
      srst = 1'b0;
      #1;
      check("srst_busy", busy, 1'b0);
      check("srst_data", out_data, 32'h0);
      check("srst_no_beats", bq_d.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
